// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_unit_if
//  Purpose  : Bundles the fetch PC unit's control inputs (hazard stall,
//             D-stage redirect, CP0 exception/eret) and its F-side IF/ID
//             payload outputs.
//  Modports : master - hazard unit / D stage / CP0 side (drives controls,
//                      receives F-side payload)
//             slave  - fetch_pc_unit itself
//  Signals  : stall, npc_valid, npc_target[31:0], D_is_branch,
//             D_branch_likely, D_branch_taken, exc_req, eret_req, epc[31:0]
//             -> F_PC[31:0], F_PC8[31:0], F_exc[4:0], F_BD, likely,
//             redirect_pending
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_pc_unit_if;
    logic        stall;
    logic        npc_valid;
    logic [31:0] npc_target;
    logic        D_is_branch;
    logic        D_branch_likely;
    logic        D_branch_taken;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;

    logic [31:0] F_PC;
    logic [31:0] F_PC8;
    logic [4:0]  F_exc;
    logic        F_BD;
    logic        likely;
    logic        redirect_pending;

    modport master (
        output stall, npc_valid, npc_target, D_is_branch, D_branch_likely,
               D_branch_taken, exc_req, eret_req, epc,
        input  F_PC, F_PC8, F_exc, F_BD, likely, redirect_pending
    );

    modport slave (
        input  stall, npc_valid, npc_target, D_is_branch, D_branch_likely,
               D_branch_taken, exc_req, eret_req, epc,
        output F_PC, F_PC8, F_exc, F_BD, likely, redirect_pending
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_unit
//  Purpose  : Fetch-stage PC generator. Holds the architectural fetch PC,
//             selects the next PC (exception > eret > stall > held redirect
//             > redirect > sequential) and produces the F-side IF/ID
//             payload. F_PC doubles as the instruction-memory address.
//  Ports    : clk   - system clock
//             reset - asynchronous, active-high reset
//             bus   - fetch_pc_unit_if.slave (controls in, F payload out)
//  Config   : FETCH_ADEL_CHECK_EN - when defined, F_exc flags misaligned or
//             out-of-range fetch addresses with EXC_ADEL; when undefined,
//             F_exc is tied to zero and no address checker is built.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    fetch_pc_unit_if.slave      bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,   // no redirect held
        ST_HOLD = 1'b1    // redirect captured during a stall, waiting
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_pend_target;
    logic [31:0] w_pend_next;

    // ------------------------------------------------------------------
    // State / PC registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_pend_target <= 32'd0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_pend_target <= w_pend_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-PC selection
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_pend_next  = r_pend_target;

        if (bus.exc_req) begin
            // Pipe flush: any held redirect belongs to squashed code.
            w_pc_next    = HANDLER_PC;
            w_state_next = ST_RUN;
            w_pend_next  = 32'd0;
        end else if (bus.eret_req) begin
            w_pc_next    = bus.epc;
            w_state_next = ST_RUN;
            w_pend_next  = 32'd0;
        end else if (bus.stall) begin
            // PC frozen; a redirect arriving now must not be lost because
            // npc_valid is only a one-cycle pulse. Latest one wins.
            if (bus.npc_valid) begin
                w_pend_next  = bus.npc_target;
                w_state_next = ST_HOLD;
            end
        end else if (r_state == ST_HOLD) begin
            // A fresh redirect is younger than the held one, so it wins.
            w_pc_next    = bus.npc_valid ? bus.npc_target : r_pend_target;
            w_state_next = ST_RUN;
        end else if (bus.npc_valid) begin
            w_pc_next    = bus.npc_target;
        end else begin
            w_pc_next    = r_pc + 32'd4;
        end
    end

    // ------------------------------------------------------------------
    // F-side payload
    // ------------------------------------------------------------------
    assign bus.F_PC             = r_pc;
    assign bus.F_PC8            = r_pc + 32'd8;
    assign bus.F_BD             = bus.D_is_branch & ~bus.exc_req & ~bus.eret_req;
    // Not-taken branch-likely: the delay slot being captured this cycle is
    // annulled, so IF/ID turns it into a bubble. Only meaningful when IF/ID
    // actually writes (no stall) and the pipe is not being flushed anyway.
    assign bus.likely           = bus.D_branch_likely & ~bus.D_branch_taken &
                                  ~bus.stall & ~bus.exc_req;
    assign bus.redirect_pending = (r_state == ST_HOLD);

`ifdef FETCH_ADEL_CHECK_EN
    logic w_adel;
    assign w_adel    = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_LIMIT);
    assign bus.F_exc = w_adel ? EXC_ADEL : 5'd0;
`else
    // Address checking compiled out; the parameters are only referenced
    // here so the configuration stays uniform across both builds.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{IM_BASE, IM_LIMIT, EXC_ADEL};
    assign bus.F_exc    = 5'd0;
`endif

endmodule
`default_nettype wire
